sfx_sequencer: RTL and testbench
================================

Name: sfx_sequencer

Overview:
- Drives the APU's `snare_trigger` input. It turns one-cycle game sound-event requests into timed trigger patterns, aligned to frame boundaries.
- Requests are queued in a small FIFO. Each queued event plays a fixed 8-step rhythm pattern, one step every STEP_FRAMES frames.
- Sits between game logic (collision/shoot/score event strobes) and the APU; shares the pixel clock and `frame_end`.

Parameters:
- STEP_FRAMES, 8, frames per pattern step; legal range 2..255.
- FIFO_DEPTH, 4, event queue entries; power of two, 2..16.
- PATTERN0, 8'b0000_0001, rhythm for event id 0; bit 0 plays first.
- PATTERN1, 8'b0000_0101, rhythm for event id 1.
- PATTERN2, 8'b0101_0101, rhythm for event id 2.
- PATTERN3, 8'b1111_1111, rhythm for event id 3.

Ports:
- clk  input  1  system/pixel clock.
- reset  input  1  synchronous, active-high reset.
- frame_end  input  1  one-cycle pulse, once per video frame.
- event_req  input  4  one-cycle request strobes; bit i requests event id i.
- snare_trigger  output  1  registered level to the APU, held for whole frames.
- busy  output  1  high while a pattern is playing.
- queue_level  output  $clog2(FIFO_DEPTH)+1  number of queued events.
- queue_full  output  1  queue_level == FIFO_DEPTH.
- event_dropped  output  1  one-cycle pulse when a request is discarded.

Behaviour:
- Reset values: snare_trigger=0, busy=0, queue_level=0, queue_full=0, event_dropped=0.
- Reset is honoured mid-pattern: FSM returns to IDLE, FIFO is emptied, snare_trigger=0 on the cycle after reset is sampled.
- Request arbitration: at most one enqueue per cycle.
  - If several event_req bits are set, the highest index is enqueued.
  - The lower bits are discarded, with event_dropped=1 for that cycle (one pulse regardless of how many bits were lost).
- FIFO, holding 2-bit ids:
  - Enqueue when full: request dropped, event_dropped=1.
  - Enqueue and dequeue in the same cycle while full: the enqueue is accepted; level is unchanged.
  - Dequeue when empty never occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, PLAY. Counters: step[2:0], fdiv[7:0]; registers cur_id, cur_pat.
- IDLE:
  - On a frame_end cycle with queue_level>0: pop head, cur_pat=PATTERN[id], step=0, fdiv=0, go to PLAY.
  - In the same cycle, snare_trigger <= cur_pat bit 0.
  - frame_end with an empty queue: no action; snare_trigger stays 0.
- PLAY, on each frame_end:
  - Advance fdiv. When fdiv wraps from STEP_FRAMES-1 to 0, step increments.
  - snare_trigger <= cur_pat[new step] when new fdiv==0, else 0.
  - The trigger is therefore high for exactly the first frame of each set step. Because STEP_FRAMES≥2, it is low for at least one frame between hits, so every hit gives the APU a rising edge.
- End of pattern:
  - On the frame_end where step==7 and fdiv==STEP_FRAMES-1, the pattern ends.
  - If the queue is non-empty, the next id is popped in that same cycle and its bit 0 is driven, giving back-to-back playback with no gap frame.
  - Otherwise go to IDLE with snare_trigger <= 0.
- busy = (state==PLAY).
- Latency: first trigger rises 1 clk after the frame_end that pops the event.
- Pattern duration is 8*STEP_FRAMES frames.
- Between frame_end pulses, snare_trigger, step and fdiv are static.

Optional Feature:
- Macro: SFX_PREEMPT_EN.
- Defined:
  - While in PLAY, a request whose id > cur_id bypasses the FIFO and is latched as a pending preempt. A later, higher id overwrites the pending one.
  - At the next frame_end, playback restarts with the pending pattern (step=0, fdiv=0, trigger=bit 0). The FIFO contents are untouched.
  - Requests with id ≤ cur_id enqueue normally.
  - In IDLE, all requests enqueue.
- Undefined: every request goes through the FIFO; no preemption logic is synthesised.

Test Plan:
- After reset, event_req=4'b0001, then frame_end every 100 clks, STEP_FRAMES=8:
  - snare_trigger high for exactly 1 frame, starting 1 clk after the first frame_end;
  - busy high for 64 frames; then IDLE, queue_level=0.
- event_req=4'b1000 (PATTERN3):
  - 8 trigger pulses, each 1 frame high, 7 frames low;
  - 8 rising edges in total.
- Five requests (ids 0,1,2,3,0) before any frame_end:
  - the first four are queued, queue_full=1;
  - the fifth gives event_dropped=1 for 1 clk;
  - patterns then play back-to-back with no idle frame; total busy=256 frames.
- event_req=4'b0110 in a single cycle:
  - id 2 enqueued, event_dropped=1, queue_level=1.
- Assert reset during step 3 of PATTERN2 with 2 events queued:
  - the next cycle shows snare_trigger=0, busy=0, queue_level=0;
  - subsequent frame_end pulses produce no triggers.
- With SFX_PREEMPT_EN defined: playing id 0 at step 2, request id 3:
  - at the next frame_end, snare_trigger=1 and the PATTERN3 sequence starts;
  - queue_level unchanged.

Source files
------------

// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if -- game/APU side bundle of the sound-effect sequencer.
//   frame_end      one-cycle pulse per video frame
//   event_req[3:0] one-cycle request strobes, bit i = event id i
//   snare_trigger  registered level to the APU, changes only after frame_end
//   busy           a pattern is playing
//   queue_level    number of queued event ids
//   queue_full     queue_level == FIFO_DEPTH
//   event_dropped  one-cycle pulse, a request was discarded
// master = request source (game logic / bench), slave = sequencer.
interface sfx_sequencer_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          frame_end;
  logic [3:0]    event_req;
  logic          snare_trigger;
  logic          busy;
  logic [LW-1:0] queue_level;
  logic          queue_full;
  logic          event_dropped;

  modport master (
    output frame_end, event_req,
    input  snare_trigger, busy, queue_level, queue_full, event_dropped
  );

  modport slave (
    input  frame_end, event_req,
    output snare_trigger, busy, queue_level, queue_full, event_dropped
  );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer -- turns one-cycle sound-event strobes into frame-aligned
// 8-step rhythm patterns on the APU snare trigger.
//
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high
//   bus    sfx_sequencer_if.slave (frame_end, event_req in;
//          snare_trigger, busy, queue_level, queue_full, event_dropped out)
//
// Requests are arbitrated (highest id wins, losers flagged as dropped) and
// queued in a FIFO_DEPTH-entry FIFO of 2-bit ids. On a frame_end the head is
// popped and its pattern plays, one step every STEP_FRAMES frames; the
// trigger is high only for the first frame of each set step.
//
// Optional build macro SFX_PREEMPT_EN: while playing, a request with an id
// above the playing id skips the FIFO and restarts playback with its pattern
// at the next frame_end. Without the macro no preemption logic exists.
module sfx_sequencer #(
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  PATTERN0    = 8'b0000_0001,
  parameter logic [7:0]  PATTERN1    = 8'b0000_0101,
  parameter logic [7:0]  PATTERN2    = 8'b0101_0101,
  parameter logic [7:0]  PATTERN3    = 8'b1111_1111
) (
  input  logic           clk,
  input  logic           reset,
  sfx_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    FDIV_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic [7:0] pat_of(input logic [1:0] id);
    case (id)
      2'd0:    pat_of = PATTERN0;
      2'd1:    pat_of = PATTERN1;
      2'd2:    pat_of = PATTERN2;
      default: pat_of = PATTERN3;
    endcase
  endfunction

  state_t     state, state_nxt;
  logic [2:0] step, step_nxt;
  logic [7:0] fdiv, fdiv_nxt;
  logic [7:0] cur_pat, cur_pat_nxt;
  logic       trig, trig_nxt;
  logic       dropped, dropped_nxt;

  // FIFO of event ids
  logic [FIFO_DEPTH-1:0][1:0] fifo_mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [LW-1:0]              level;
  logic [1:0]                 head_id;
  logic                       push, pop;

  assign head_id = fifo_mem[rd_ptr];

  // Request arbitration: highest set bit wins, any other set bit is lost.
  logic       req_vld, req_lost;
  logic [1:0] req_id;

  always_comb begin
    req_vld  = |bus.event_req;
    req_lost = |(bus.event_req & (bus.event_req - 4'd1));
    req_id   = 2'd0;
    for (int i = 0; i < 4; i++)
      if (bus.event_req[i]) req_id = 2'(i);
  end

  logic       bypass;   // request goes to the preempt slot, not the FIFO
  logic       preempt;  // restart with the pending id on this frame_end

`ifdef SFX_PREEMPT_EN
  logic [1:0] cur_id;
  logic       pend_vld, pend_live;
  logic [1:0] pend_id;

  assign bypass  = req_vld && (state == PLAY) && (req_id > cur_id);
  assign preempt = bus.frame_end && (state == PLAY) && pend_vld;
  // A pending id survives this cycle unless it is consumed right now.
  assign pend_live = pend_vld && !preempt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_id  <= 2'd0;
    end else if (bypass && (!pend_live || req_id > pend_id)) begin
      pend_vld <= 1'b1;
      pend_id  <= req_id;
    end else begin
      pend_vld <= pend_live;
    end
  end
`else
  assign bypass  = 1'b0;
  assign preempt = 1'b0;
`endif

  // Next-state / datapath. All movement happens on frame_end only, so the
  // trigger, step and fdiv are static between frames.
  logic       load;
  logic [1:0] load_id;
  logic [2:0] step_inc;

  assign step_inc = step + 3'd1;

  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    fdiv_nxt    = fdiv;
    cur_pat_nxt = cur_pat;
    trig_nxt    = trig;
    pop         = 1'b0;
    load        = 1'b0;
    load_id     = head_id;
    if (bus.frame_end) begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            pop  = 1'b1;
            load = 1'b1;
          end
        end
        PLAY: begin
          if (preempt) begin
`ifdef SFX_PREEMPT_EN
            load_id = pend_id;
`endif
            load = 1'b1;
          end else if (fdiv == FDIV_LAST) begin
            fdiv_nxt = 8'd0;
            if (step == 3'd7) begin
              // Pattern done: chain the next queued id with no gap frame.
              if (level != '0) begin
                pop  = 1'b1;
                load = 1'b1;
              end else begin
                state_nxt = IDLE;
                trig_nxt  = 1'b0;
              end
            end else begin
              step_nxt = step_inc;
              trig_nxt = cur_pat[step_inc];
            end
          end else begin
            fdiv_nxt = fdiv + 8'd1;
            trig_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (load) begin
        state_nxt   = PLAY;
        step_nxt    = 3'd0;
        fdiv_nxt    = 8'd0;
        cur_pat_nxt = pat_of(load_id);
        trig_nxt    = cur_pat_nxt[0];
      end
    end
  end

  // A full FIFO still accepts when it pops in the same cycle.
  always_comb begin
    push        = req_vld && !bypass && ((level != LVL_FULL) || pop);
    dropped_nxt = req_lost || (req_vld && !bypass && !push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step    <= 3'd0;
      fdiv    <= 8'd0;
      cur_pat <= 8'd0;
      trig    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      fdiv    <= fdiv_nxt;
      cur_pat <= cur_pat_nxt;
      trig    <= trig_nxt;
      dropped <= dropped_nxt;
    end
  end

`ifdef SFX_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (reset)     cur_id <= 2'd0;
    else if (load) cur_id <= load_id;
  end
`endif

  // FIFO storage needs no reset; only the pointers and level define content.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign bus.snare_trigger = trig;
  assign bus.busy          = (state == PLAY);
  assign bus.queue_level   = level;
  assign bus.queue_full    = (level == LVL_FULL);
  assign bus.event_dropped = dropped;

endmodule

// File: tb/tb_sfx_sequencer.sv
module tb_sfx_sequencer;
  localparam int SF    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  sfx_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  sfx_sequencer #(.STEP_FRAMES(SF), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pattern is a run of 8*SF frames indexed by m_k; the trigger is set for
  // the first frame of each SF-frame slot whose pattern bit is 1.
  logic [7:0] PAT [4];
  initial begin
    PAT[0] = 8'b0000_0001;
    PAT[1] = 8'b0000_0101;
    PAT[2] = 8'b0101_0101;
    PAT[3] = 8'b1111_1111;
  end

  int mq[$];
  bit m_play, m_trig, m_drop, m_ok;
  int m_cur, m_k, m_pend;
  int hi, nreq;
  bit byp;

  task automatic m_start(input int id);
    m_play = 1'b1;
    m_cur  = id;
    m_k    = 0;
    m_trig = PAT[id][0];
  endtask

  initial begin
    m_ok = 1'b0; m_play = 0; m_trig = 0; m_drop = 0; m_pend = -1; m_cur = 0; m_k = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_play = 0; m_trig = 0; m_drop = 0; m_k = 0; m_cur = 0; m_pend = -1;
      m_ok = 1'b1;
    end else begin
      hi = -1; nreq = 0;
      for (int i = 0; i < 4; i++)
        if (bus.event_req[i]) begin hi = i; nreq++; end
      byp = 1'b0;
`ifdef SFX_PREEMPT_EN
      byp = (hi >= 0) && m_play && (hi > m_cur);
`endif
      if (bus.frame_end) begin
        if (m_play && m_pend >= 0) begin
          m_start(m_pend);
          m_pend = -1;
        end else if (m_play) begin
          m_k++;
          if (m_k == 8*SF) begin
            if (mq.size() > 0) m_start(mq.pop_front());
            else begin m_play = 0; m_trig = 0; end
          end else begin
            m_trig = (m_k % SF == 0) ? PAT[m_cur][m_k / SF] : 1'b0;
          end
        end else if (mq.size() > 0) begin
          m_start(mq.pop_front());
        end
      end
      m_drop = (nreq > 1);
      if (hi >= 0) begin
        if (byp) begin
          if (m_pend < 0 || hi > m_pend) m_pend = hi;
        end else if (mq.size() < DEPTH) mq.push_back(hi);
        else m_drop = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("snare_trigger", 32'(bus.snare_trigger), 32'(m_trig));
      chk("busy",          32'(bus.busy),          32'(m_play));
      chk("queue_level",   32'(bus.queue_level),   32'(mq.size()));
      chk("queue_full",    32'(bus.queue_full),    32'(mq.size() == DEPTH));
      chk("event_dropped", 32'(bus.event_dropped), 32'(m_drop));
    end
  end

  // ---------------- stimulus ----------------
  int rises, hi_cyc, busy_cyc, busy_falls;
  bit prev_trig, prev_busy;

  task automatic clr_cnt();
    rises = 0; hi_cyc = 0; busy_cyc = 0; busy_falls = 0;
  endtask

  // Called at a negedge: apply inputs for one cycle, return at next negedge.
  task automatic drive(input bit fe, input logic [3:0] req);
    bus.frame_end = fe;
    bus.event_req = req;
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.event_req = 4'd0;
    if (bus.snare_trigger && !prev_trig) rises++;
    if (bus.snare_trigger) hi_cyc++;
    if (bus.busy) busy_cyc++;
    if (!bus.busy && prev_busy) busy_falls++;
    prev_trig = bus.snare_trigger;
    prev_busy = bus.busy;
  endtask

  task automatic run_frames(input int n, input int period);
    for (int f = 0; f < n; f++) begin
      drive(1'b1, 4'd0);
      for (int c = 1; c < period; c++) drive(1'b0, 4'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'd0);
    drive(1'b0, 4'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_end = 1'b0;
    bus.event_req = 4'd0;
    prev_trig = 0; prev_busy = 0;
    clr_cnt();
    @(negedge clk);
    drive(1'b0, 4'd0);
    reset = 1'b0;
    chk("reset_trigger", 32'(bus.snare_trigger), 0);
    chk("reset_busy",    32'(bus.busy), 0);
    chk("reset_level",   32'(bus.queue_level), 0);

    // Single id 0, frames every 100 clks: one 1-frame pulse, 64 busy frames.
    drive(1'b0, 4'b0001);
    chk("t1_level", 32'(bus.queue_level), 1);
    clr_cnt();
    drive(1'b1, 4'd0);
    chk("t1_latency", 32'(bus.snare_trigger), 1);
    for (int c = 1; c < 100; c++) drive(1'b0, 4'd0);
    run_frames(65, 100);
    chk("t1_rises",   32'(rises), 1);
    chk("t1_hi_cyc",  32'(hi_cyc), 100);
    chk("t1_busy",    32'(busy_cyc), 64*100);
    chk("t1_idle",    32'(bus.busy), 0);
    chk("t1_level0",  32'(bus.queue_level), 0);

    // PATTERN3: 8 one-frame pulses.
    do_reset();
    drive(1'b0, 4'b1000);
    clr_cnt();
    run_frames(66, 20);
    chk("t2_rises",  32'(rises), 8);
    chk("t2_hi_cyc", 32'(hi_cyc), 8*20);

    // Five requests before any frame: fill, drop, then back-to-back play.
    do_reset();
    drive(1'b0, 4'b0001);
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b0100);
    drive(1'b0, 4'b1000);
    chk("t3_full", 32'(bus.queue_full), 1);
    drive(1'b0, 4'b0001);
    chk("t3_drop", 32'(bus.event_dropped), 1);
    drive(1'b0, 4'd0);
    chk("t3_drop_1clk", 32'(bus.event_dropped), 0);
    clr_cnt();
    run_frames(260, 20);
    chk("t3_busy",  32'(busy_cyc), 256*20);
    chk("t3_falls", 32'(busy_falls), 1);

    // Multi-bit request: id 2 wins, lower bit dropped.
    do_reset();
    drive(1'b0, 4'b0110);
    chk("t4_drop",  32'(bus.event_dropped), 1);
    chk("t4_level", 32'(bus.queue_level), 1);

    // Reset mid-pattern (step 3 of PATTERN2, two queued).
    do_reset();
    drive(1'b0, 4'b0100);
    run_frames(1, 20);
    drive(1'b0, 4'b0001);
    drive(1'b0, 4'b0010);
    run_frames(25, 20);
    chk("t5_level_pre", 32'(bus.queue_level), 2);
    chk("t5_busy_pre",  32'(bus.busy), 1);
    reset = 1'b1;
    drive(1'b0, 4'd0);
    reset = 1'b0;
    chk("t5_trig", 32'(bus.snare_trigger), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_level", 32'(bus.queue_level), 0);
    clr_cnt();
    run_frames(10, 20);
    chk("t5_no_trig", 32'(rises), 0);

`ifdef SFX_PREEMPT_EN
    // Preempt: id 0 at step 2, id 3 requested, restart with PATTERN3.
    do_reset();
    drive(1'b0, 4'b0001);
    run_frames(1, 20);
    drive(1'b0, 4'b0001);
    run_frames(16, 20);
    drive(1'b0, 4'b1000);
    chk("pre_level", 32'(bus.queue_level), 1);
    drive(1'b1, 4'd0);
    chk("pre_trig",  32'(bus.snare_trigger), 1);
    chk("pre_level_after", 32'(bus.queue_level), 1);
    run_frames(10, 20);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 1999) == 0) reset = 1'b1;
      drive(($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
